multicycle_ctrl_fsm: RTL and testbench

//  Main control sequencer for the multi-cycle MIPS-subset datapath: shared IR/MDR/A/B/ALUOut registers, one shared memory, one ALU.

---
 rtl/mc_ctrl_pkg.sv | 63 ++++++
 rtl/mc_ctrl_outdec.sv | 79 +++++++
 rtl/multicycle_ctrl_fsm.sv | 85 ++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle control sequencer
package mc_ctrl_pkg;
    localparam int ST_W    = 4;
    localparam int ALUOP_W = 3;
    typedef enum logic [ST_W-1:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_EXEC_I    = 4'd8,
        ST_I_WB      = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_JAL       = 4'd12
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_R   = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b011;
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;
    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic [1:0]         branch_type;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic [1:0]         reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         pc_source;
        logic               illegal;
    } ctrl_t;
    function automatic logic legal_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW};
    endfunction
endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: state -> datapath control vector decode
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    input  logic [1:0] sub_op,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.illegal   = !legal_op(opcode);
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_R;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = REGDST_RD;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = sub_op[1] ? ALU_SLT : ALU_ADD;
            end
            ST_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = REGDST_RT;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_type   = {1'b0, sub_op[0]};
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_JAL: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = REGDST_RA;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control sequencer for the multi-cycle MIPS-subset datapath
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         opcode_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic [1:0]         BranchType_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemToReg_o,
    output logic [1:0]         RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic [1:0]         PCSource_o,
    output logic               illegal_o,
    output logic [ST_W-1:0]    state_o
);
    state_t     state, state_next;
    logic [1:0] sub_op;
    ctrl_t      ctrl, ctrl_q;
    always_comb begin
        state_next = ST_FETCH;
        case (state)
            ST_FETCH:     state_next = mem_ready_i ? ST_DECODE : ST_FETCH;
            ST_DECODE:
                case (opcode_i)
                    OP_RTYPE:      state_next = ST_EXEC_R;
                    OP_LW, OP_SW:  state_next = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next = ST_BRANCH;
                    OP_ADDI, OP_SLTI: state_next = ST_EXEC_I;
                    OP_J:          state_next = ST_JUMP;
                    OP_JAL:        state_next = ST_JAL;
                    default:       state_next = ST_FETCH;
                endcase
            ST_MEM_ADDR:  state_next = (opcode_i == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  state_next = mem_ready_i ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WRITE: state_next = mem_ready_i ? ST_FETCH : ST_MEM_WRITE;
            ST_EXEC_R:    state_next = ST_R_WB;
            ST_EXEC_I:    state_next = ST_I_WB;
            default:      state_next = ST_FETCH;
        endcase
    end
    // Opcode low bits captured in DECODE pick branch sense and addi/slti ALUOp later
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= ST_FETCH;
            sub_op <= 2'b00;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) sub_op <= opcode_i[1:0];
        end
    end
    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready_i),
        .opcode    (opcode_i),
        .sub_op    (sub_op),
        .ctrl      (ctrl)
    );
    assign ctrl_q        = rst_i ? ctrl : '0;
    assign PCWrite_o     = ctrl_q.pc_write;
    assign PCWriteCond_o = ctrl_q.pc_write_cond;
    assign BranchType_o  = ctrl_q.branch_type;
    assign IorD_o        = ctrl_q.iord;
    assign MemRead_o     = ctrl_q.mem_read;
    assign MemWrite_o    = ctrl_q.mem_write;
    assign IRWrite_o     = ctrl_q.ir_write;
    assign MemToReg_o    = ctrl_q.mem_to_reg;
    assign RegDst_o      = ctrl_q.reg_dst;
    assign RegWrite_o    = ctrl_q.reg_write;
    assign ALUSrcA_o     = ctrl_q.alu_src_a;
    assign ALUSrcB_o     = ctrl_q.alu_src_b;
    assign ALUOp_o       = ctrl_q.alu_op;
    assign PCSource_o    = ctrl_q.pc_source;
    assign illegal_o     = ctrl_q.illegal;
    assign state_o       = rst_i ? state : ST_FETCH;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed-vector self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       ready = 1'b0;
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, rw, sa, ill;
    logic [1:0] bt, rd, sb, ps;
    logic [2:0] aop;
    logic [3:0] st;
    logic [24:0] outs;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    multicycle_ctrl_fsm dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(ready),
        .PCWrite_o(pcw), .PCWriteCond_o(pcwc), .BranchType_o(bt), .IorD_o(iord),
        .MemRead_o(mr), .MemWrite_o(mw), .IRWrite_o(irw), .MemToReg_o(m2r),
        .RegDst_o(rd), .RegWrite_o(rw), .ALUSrcA_o(sa), .ALUSrcB_o(sb),
        .ALUOp_o(aop), .PCSource_o(ps), .illegal_o(ill), .state_o(st)
    );
    assign outs = {pcw, pcwc, bt, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, ill, st};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #1;
    endtask
    initial begin
        step();
        step();
        chk("rst_outs", 32'(outs), 0);
        rst = 1'b1; ready = 1'b1; opcode = 6'h23;
        settle();
        chk("f_state", 32'(st), 0);
        chk("f_memread", 32'(mr), 1);
        chk("f_srcb", 32'(sb), 1);
        step(); step(); step();
        ready = 1'b0;
        settle();
        chk("mr_state", 32'(st), 3);
        chk("mr_iord", 32'(iord), 1);
        rst = 1'b0;
        settle();
        chk("rst_mr_outs0", 32'(outs), 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("rst_mr_outs%0d", i), 32'(outs), 0);
        end
        rst = 1'b1; ready = 1'b1;
        settle();
        chk("rel_state", 32'(st), 0);
        chk("rel_memread", 32'(mr), 1);
        chk("rel_iord", 32'(iord), 0);
        begin
            int exp_st[5] = '{0, 1, 2, 3, 4};
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("lw_state%0d", i), 32'(st), 32'(exp_st[i]));
                chk($sformatf("lw_regwrite%0d", i), 32'(rw), (i == 4) ? 1 : 0);
                chk($sformatf("lw_memtoreg%0d", i), 32'(m2r), (i == 4) ? 1 : 0);
                step();
            end
        end
        chk("lw_done", 32'(st), 0);
        ready = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_state%0d", i), 32'(st), 0);
            chk($sformatf("stall_pcw%0d", i), 32'({pcw, irw}), 0);
            step();
        end
        ready = 1'b1;
        settle();
        chk("stall_go_pcw_irw", 32'({pcw, irw}), 3);
        opcode = 6'h2B;
        step();
        chk("stall_decode", 32'(st), 1);
        step();
        chk("sw_addr", 32'(st), 2);
        chk("sw_addr_src", 32'({sa, sb}), 32'b110);
        step();
        ready = 1'b0;
        settle();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("sw_wait_state%0d", i), 32'(st), 5);
            chk($sformatf("sw_wait_mw%0d", i), 32'({mw, rw}), 32'b10);
            step();
        end
        ready = 1'b1;
        settle();
        chk("sw_last_mw", 32'({mw, rw, iord}), 32'b101);
        step();
        chk("sw_done", 32'({st, mw}), 0);
        opcode = 6'h05;
        step();
        chk("bne_decode", 32'(st), 1);
        chk("bne_decode_srcb", 32'(sb), 3);
        step();
        chk("bne_state", 32'(st), 10);
        chk("bne_ctrl", 32'({pcwc, bt, aop, ps, pcw}), {1'b1, 2'd1, 3'b001, 2'd1, 1'b0});
        step();
        chk("bne_done", 32'(st), 0);
        opcode = 6'h3F;
        step();
        chk("ill_pulse", 32'({ill, rw, mw}), 32'b100);
        step();
        chk("ill_after", 32'({st, ill}), 0);
        opcode = 6'h03;
        step(); step();
        chk("jal_state", 32'(st), 12);
        chk("jal_ctrl", 32'({rd, rw, ps, pcw, sa, sb}), {2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0});
        step();
        chk("jal_done", 32'(st), 0);
        opcode = 6'h00;
        step(); step();
        chk("r_exec", 32'({st, aop, sa, sb}), {4'd6, 3'b010, 1'b1, 2'd0});
        step();
        chk("r_wb", 32'({rw, rd, m2r}), {1'b1, 2'd1, 1'b0});
        step();
        opcode = 6'h0A;
        step(); step();
        chk("slti_exec", 32'({aop, sa, sb}), {3'b011, 1'b1, 2'd2});
        step();
        chk("slti_wb", 32'({rw, rd, m2r}), {1'b1, 2'd0, 1'b0});
        step();
        chk("slti_done", 32'(st), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
